// File: rtl/lfsr_timer_pkg.sv
// Shared definitions for the LFSR interval timer: FSM encoding, standard tap masks
// and a helper that sizes the optional prescale counter.
package lfsr_timer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hD008;

  // A divide-by-1 still needs a 1-bit counter so the vector stays legal.
  function automatic int prescale_bits(input int p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/lfsr_interval_timer_if.sv
// Control/status bundle between the LCD command sequencer (master) and the
// interval timer (slave), plus read-only debug visibility of the FSM and LFSR.
interface lfsr_interval_timer_if #(
  parameter int WIDTH = 16
);
  import lfsr_timer_pkg::*;

  // EnableCount is a request sampled only while idle; DisableCount is a level
  // stop honoured on every edge; TimerIndicator is a one-cycle pulse with no
  // acknowledge, so the consumer must sample it on every clock.
  logic             EnableCount;
  logic             DisableCount;
  logic             OneShot;
  logic [WIDTH-1:0] TermState;
  logic             TimerIndicator;
  logic             Busy;
  logic             TermError;
  state_t           DbgState;
  logic [WIDTH-1:0] DbgLfsr;

  modport master (
    output EnableCount, DisableCount, OneShot, TermState,
    input  TimerIndicator, Busy, TermError, DbgState, DbgLfsr
  );

  modport slave (
    input  EnableCount, DisableCount, OneShot, TermState,
    output TimerIndicator, Busy, TermError, DbgState, DbgLfsr
  );

endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and single-step controls; load wins
// over step. The next value is exposed so callers can look ahead.
module lfsr_core #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_q;

  assign o_next = {r_q[WIDTH-2:0], ^(r_q & TAPS)};
  assign o_q    = r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= SEED;
    end else if (i_load) begin
      r_q <= SEED;
    end else if (i_step) begin
      r_q <= o_next;
    end
  end

endmodule

// File: rtl/lfsr_interval_timer.sv
// LFSR interval timer: counts from SEED to a latched terminal value and emits a
// registered one-cycle tick. Optional step prescaler under LFSR_TIMER_PRESCALE_EN.
module lfsr_interval_timer
  import lfsr_timer_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED     = '1,
  parameter int               PRESCALE = 1
) (
  input  logic                  clock,
  input  logic                  rst,
  lfsr_interval_timer_if.slave  bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_term;
  logic             r_oneshot;
  logic             r_tick;
  logic             r_err;
  logic [WIDTH-1:0] w_lfsr;
  logic [WIDTH-1:0] w_lfsr_next;
  logic             w_match;
  logic             w_strobe;
  logic             w_load;
  logic             w_step;
  logic             w_tick_d;
  logic             w_latch;
  logic             w_err_set;
  logic             w_err_clr;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .i_clk   (clock),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .o_q     (w_lfsr),
    .o_next  (w_lfsr_next)
  );

`ifdef LFSR_TIMER_PRESCALE_EN
  localparam int PW = prescale_bits(PRESCALE);

  logic [PW-1:0] r_pre;
  logic          w_pre_clr;

  // Counting restarts from zero on every entry to COUNT, so the first step
  // lands PRESCALE cycles after the enable edge.
  assign w_pre_clr = bus.DisableCount || (r_state != COUNT);
  assign w_strobe  = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (w_pre_clr || w_strobe) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end
`else
  // Every cycle is a step edge; PRESCALE has no effect in this build.
  assign w_strobe = 1'b1 | (PRESCALE < 1);
`endif

  assign w_match = (w_lfsr == r_term);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_tick_d     = 1'b0;
    w_latch      = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    if (bus.DisableCount) begin
      w_next_state = IDLE;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_load = 1'b1;
          if (bus.EnableCount) begin
            w_latch = 1'b1;
            // Zero is never reached by a non-zero seed, so refuse to start.
            if (bus.TermState != '0) begin
              w_next_state = COUNT;
              w_err_clr    = 1'b1;
            end else begin
              w_err_set = 1'b1;
            end
          end
        end
        COUNT: begin
          if (w_strobe) begin
            if (w_match) begin
              w_tick_d = 1'b1;
              w_load   = 1'b1;
              if (r_oneshot) begin
                w_next_state = IDLE;
              end
            end else begin
              w_step = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = IDLE;
          w_load       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_term    <= '0;
      r_oneshot <= 1'b0;
      r_tick    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tick <= w_tick_d;
      if (w_latch) begin
        r_term    <= bus.TermState;
        r_oneshot <= bus.OneShot;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.TimerIndicator = r_tick;
  assign bus.Busy           = (r_state == COUNT);
  assign bus.TermError      = r_err;
  assign bus.DbgState       = r_state;
  assign bus.DbgLfsr        = w_lfsr;

endmodule

// File: tb/tb_lfsr_interval_timer.sv
// Bench for lfsr_interval_timer (WIDTH=4, taps 4'hC, seed 4'hF): directed
// scenarios plus random traffic against a cycle-count reference model.
module tb_lfsr_interval_timer;
  import lfsr_timer_pkg::*;

  localparam int             W    = 4;
  localparam logic [W-1:0]   TAPS = TAPS_W4;
  localparam logic [W-1:0]   SEED = 4'hF;
`ifdef LFSR_TIMER_PRESCALE_EN
  localparam int             P    = 3;
`else
  localparam int             P    = 1;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  lfsr_interval_timer_if #(.WIDTH(W)) bus ();

  lfsr_interval_timer #(
    .WIDTH    (W),
    .TAPS     (TAPS),
    .SEED     (SEED),
    .PRESCALE (3)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: orbit of the LFSR from SEED, then pure cycle counting
  logic [W-1:0] orbit[$];
  logic         m_busy, m_tick, m_err, m_oneshot;
  int           m_cnt, m_k;
  int           cyc_no;
  int           seen_q[$];
  int           exp_q[$];

  function automatic int k_of(input logic [W-1:0] t);
    for (int i = 0; i < orbit.size(); i++)
      if (orbit[i] == t) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] m_lfsr();
    if (!m_busy) return SEED;
    if (m_k < 0) return orbit[(m_cnt / P) % orbit.size()];
    return orbit[(m_cnt / P) % (m_k + 1)];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tick = 0; m_err = 0; m_oneshot = 0; m_cnt = 0; m_k = -1;
  endtask

  task automatic model_edge();
    if (bus.DisableCount) begin
      m_busy = 0;
      m_tick = 0;
    end else if (!m_busy) begin
      m_tick = 0;
      if (bus.EnableCount) begin
        if (bus.TermState == '0) m_err = 1;
        else begin
          m_err = 0; m_busy = 1; m_cnt = 0;
          m_oneshot = bus.OneShot;
          m_k = k_of(bus.TermState);
        end
      end
    end else begin
      m_cnt++;
      if (m_k >= 0 && (m_cnt % ((m_k + 1) * P)) == 0) begin
        m_tick = 1;
        if (m_oneshot) m_busy = 0;
      end else begin
        m_tick = 0;
      end
    end
  endtask

  // one clock: advance model with the inputs presented, then compare
  task automatic cyc();
    model_edge();
    @(posedge clock);
    cyc_no++;
    #1;
    check("tick",  bus.TimerIndicator, m_tick);
    check("busy",  bus.Busy, m_busy);
    check("err",   bus.TermError, m_err);
    check("state", bus.DbgState, m_busy);
    check("lfsr",  bus.DbgLfsr, m_lfsr());
    if (bus.TimerIndicator) seen_q.push_back(cyc_no);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic start(input logic [W-1:0] term, input logic os);
    bus.EnableCount = 1'b1;
    bus.TermState   = term;
    bus.OneShot     = os;
    seen_q.delete();
    cyc_no = -1;
    cyc();
    bus.EnableCount = 1'b0;
  endtask

  task automatic stop();
    bus.DisableCount = 1'b1;
    cyc();
    bus.DisableCount = 1'b0;
  endtask

  task automatic check_ticks(input string tag);
    int got;
    check({tag, "_count"}, seen_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      got = (seen_q.size() > 0) ? seen_q.pop_front() : -1;
      check(tag, got, exp_q.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    bus.EnableCount  = 1'b0;
    bus.DisableCount = 1'b0;
    bus.OneShot      = 1'b0;
    bus.TermState    = '0;
    v = SEED;
    do begin
      orbit.push_back(v);
      v = {v[W-2:0], ^(v & TAPS)};
    end while (v != SEED && orbit.size() <= (1 << W));
    model_reset();
    cyc_no = 0;

    // reset state
    #12;
    check("rst_tick", bus.TimerIndicator, 1'b0);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_err",  bus.TermError, 1'b0);
    check("rst_lfsr", bus.DbgLfsr, SEED);
    @(negedge clock);
    rst = 1'b1;

    // periodic, term 2 (K=5)
    check("k_of_2", k_of(4'h2), 5);
    start(4'h2, 1'b0);
    run(18 * P);
    for (int i = 1; i <= 3; i++) exp_q.push_back(6 * P * i);
    check_ticks("periodic");
    stop();

    // one-shot
    start(4'h2, 1'b1);
    run(6 * P + 30);
    exp_q.push_back(6 * P);
    check_ticks("oneshot");

    // disable on the match edge
    start(4'h2, 1'b0);
    run(6 * P - 1);
    bus.DisableCount = 1'b1;
    cyc();
    bus.DisableCount = 1'b0;
    check("dis_no_tick", bus.TimerIndicator, 1'b0);
    check("dis_idle",    bus.DbgState, IDLE);
    check("dis_lfsr",    bus.DbgLfsr, 4'hF);
    check("dis_seen",    seen_q.size(), 0);
    start(4'h2, 1'b0);
    run(6 * P);
    exp_q.push_back(6 * P);
    check_ticks("reenable");
    stop();

    // zero term
    start(4'h0, 1'b0);
    check("zero_err",  bus.TermError, 1'b1);
    check("zero_busy", bus.Busy, 1'b0);
    run(12);
    check("zero_seen", seen_q.size(), 0);
    start(4'h2, 1'b0);
    check("zero_clr", bus.TermError, 1'b0);
    run(6 * P);
    exp_q.push_back(6 * P);
    check_ticks("after_zero");

    // term equal to seed ticks on every step
    stop();
    start(SEED, 1'b0);
    run(4 * P);
    for (int i = 1; i <= 4; i++) exp_q.push_back(P * i);
    check_ticks("term_seed");
    stop();

    // asynchronous reset between edges
    start(4'h2, 1'b0);
    run(3);
    @(negedge clock);
    rst = 1'b0;
    #1;
    check("arst_busy", bus.Busy, 1'b0);
    check("arst_tick", bus.TimerIndicator, 1'b0);
    check("arst_err",  bus.TermError, 1'b0);
    check("arst_lfsr", bus.DbgLfsr, SEED);
    model_reset();
    @(negedge clock);
    rst = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.EnableCount  = ($urandom_range(0, 5) == 0);
      bus.DisableCount = ($urandom_range(0, 49) == 0);
      bus.OneShot      = $urandom_range(0, 1);
      bus.TermState    = W'($urandom_range(0, (1 << W) - 1));
      cyc();
    end
    bus.EnableCount  = 1'b0;
    bus.DisableCount = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
